// File: rtl/vga_plot_sink.sv
// Pixel-plot receiver with a 160x120x3 framebuffer, a clear sequencer,
// a registered read port and saturating plot/drop tallies.
module vga_plot_sink #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic        clear_done,
  output logic        busy,
  input  logic [7:0]  rd_x,
  input  logic [6:0]  rd_y,
  output logic [2:0]  rd_colour,
  output logic [15:0] plot_count,
  output logic [7:0]  drop_count
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam logic [7:0]  W8   = 8'(WIDTH);
  localparam logic [6:0]  H7   = 7'(HEIGHT);
  localparam logic [14:0] W15  = 15'(WIDTH);
  localparam logic [14:0] LAST = 15'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state;
  logic [14:0] clr_addr;
  logic [14:0] plot_addr;
  logic [14:0] rd_addr;
  logic        plot_ok;
  logic        rd_ok;
  logic        acc;
  logic        we;
  logic [14:0] wa;
  logic [2:0]  wd;

  logic [2:0] fb [DEPTH];

  assign plot_ok   = (vga_x < W8) && (vga_y < H7);
  assign rd_ok     = (rd_x < W8) && (rd_y < H7);
  assign plot_addr = 15'(vga_y) * W15 + 15'(vga_x);
  assign rd_addr   = 15'(rd_y) * W15 + 15'(rd_x);
  assign acc       = vga_plot && plot_ok;

  // An accepted plot owns the single write port; the clear stalls.
  always_comb begin
    we = 1'b0;
    wa = clr_addr;
    wd = clear_colour;
    if (!rst) begin
      if (acc) begin
        we = 1'b1;
        wa = plot_addr;
        wd = vga_colour;
      end else if (state == S_CLEAR) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) fb[wa] <= wd;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_colour <= 3'd0;
    else     rd_colour <= rd_ok ? fb[rd_addr] : 3'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      clr_addr <= 15'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            state    <= S_CLEAR;
            clr_addr <= 15'd0;
          end
        end
        S_CLEAR: begin
          if (!acc) begin
            if (clr_addr == LAST) begin
              state    <= S_DONE;
              clr_addr <= 15'd0;
            end else begin
              clr_addr <= clr_addr + 15'd1;
            end
          end
        end
        S_DONE: begin
          if (!clear_start) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      plot_count <= 16'd0;
      drop_count <= 8'd0;
    end else begin
      if (acc && plot_count != 16'hffff)
        plot_count <= plot_count + 16'd1;
      if (vga_plot && !plot_ok && drop_count != 8'hff)
        drop_count <= drop_count + 8'd1;
    end
  end

  assign busy       = (state == S_CLEAR);
  assign clear_done = (state == S_DONE);

endmodule

// File: tb/tb_vga_plot_sink.sv
// Randomized bench for vga_plot_sink against a pixel-array reference model,
// plus literal expectations for the directed scenarios.
module tb_vga_plot_sink;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  vga_x = 8'd0;
  logic [6:0]  vga_y = 7'd0;
  logic [2:0]  vga_colour = 3'd0;
  logic        vga_plot = 1'b0;
  logic        clear_start = 1'b0;
  logic [2:0]  clear_colour = 3'd0;
  logic        clear_done;
  logic        busy;
  logic [7:0]  rd_x = 8'd0;
  logic [6:0]  rd_y = 7'd0;
  logic [2:0]  rd_colour;
  logic [15:0] plot_count;
  logic [7:0]  drop_count;

  vga_plot_sink dut (
    .clk(clk), .rst(rst),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
    .vga_plot(vga_plot),
    .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_done(clear_done), .busy(busy),
    .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
    .plot_count(plot_count), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int busy_cycles = 0;

  // Reference model: pixel array (-1 = never written) and clear progress.
  int fb [19200];
  bit m_clr, m_done, m_acc;
  int m_ptr, m_pc, m_dc, m_rd;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    for (int i = 0; i < 19200; i++) fb[i] = -1;
    m_clr = 0; m_done = 0; m_ptr = 0; m_pc = 0; m_dc = 0; m_rd = 0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_clr = 0; m_done = 0; m_ptr = 0; m_pc = 0; m_dc = 0; m_rd = 0;
    end else begin
      m_acc = vga_plot && vga_x < 160 && vga_y < 120;
      if (rd_x < 160 && rd_y < 120) m_rd = fb[int'(rd_y) * 160 + int'(rd_x)];
      else m_rd = 0;
      if (m_acc) begin
        fb[int'(vga_y) * 160 + int'(vga_x)] = int'(vga_colour);
        if (m_pc < 65535) m_pc++;
      end else if (vga_plot && m_dc < 255) begin
        m_dc++;
      end
      if (m_clr) begin
        if (!m_acc) begin
          fb[m_ptr] = int'(clear_colour);
          m_ptr++;
          if (m_ptr == 19200) begin
            m_clr = 0;
            m_done = 1;
          end
        end
      end else if (m_done) begin
        if (!clear_start) m_done = 0;
      end else if (clear_start) begin
        m_clr = 1;
        m_ptr = 0;
      end
    end
    #1;
    chk("busy", 32'(busy), 32'(m_clr));
    chk("clear_done", 32'(clear_done), 32'(m_done));
    chk("plot_count", 32'(plot_count), 32'(m_pc));
    chk("drop_count", 32'(drop_count), 32'(m_dc));
    if (m_rd >= 0) chk("rd_colour", 32'(rd_colour), 32'(m_rd));
    if (busy === 1'b1) busy_cycles++;
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic rand_rd();
    rd_x = 8'($urandom_range(0, 170));
    rd_y = 7'($urandom_range(0, 127));
  endtask

  task automatic read_at(input int x, input int y, input int exp,
                         input string name);
    rd_x = 8'(x);
    rd_y = 7'(y);
    cyc();
    chk(name, 32'(rd_colour), 32'(exp));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not end, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) cyc();
    rst = 1'b0;
    chk("reset plot_count", 32'(plot_count), 0);
    chk("reset drop_count", 32'(drop_count), 0);
    chk("reset rd_colour", 32'(rd_colour), 0);
    chk("reset busy", 32'(busy), 0);
    chk("reset clear_done", 32'(clear_done), 0);

    vga_plot = 1; vga_x = 80; vga_y = 60; vga_colour = 3'b010;
    cyc();
    vga_plot = 0; rd_x = 80; rd_y = 60;
    cyc();
    chk("plot read 80,60", 32'(rd_colour), 32'(3'b010));
    chk("plot count one", 32'(plot_count), 1);
    chk("drop count zero", 32'(drop_count), 0);

    vga_plot = 1; vga_x = 160; vga_y = 10;
    cyc();
    vga_x = 5; vga_y = 120;
    cyc();
    vga_plot = 0; rd_x = 160; rd_y = 10;
    cyc();
    chk("drop count two", 32'(drop_count), 2);
    chk("plot count held", 32'(plot_count), 1);
    chk("oor read", 32'(rd_colour), 0);

    for (int i = 0; i < 400; i++) begin
      vga_plot   = 1'($urandom_range(0, 1));
      vga_x      = 8'($urandom_range(0, 170));
      vga_y      = 7'($urandom_range(0, 127));
      vga_colour = 3'($urandom);
      rand_rd();
      cyc();
    end

    rst = 1; vga_plot = 1; vga_x = 3; vga_y = 3; vga_colour = 3'b111;
    cyc();
    rst = 0; vga_plot = 0;
    cyc();
    chk("rst beats plot", 32'(plot_count), 0);

    clear_colour = 3'b011; clear_start = 1;
    cyc();
    for (int k = 0; k < 5000; k++) begin
      vga_plot = (k == 100);
      vga_x = 159; vga_y = 119; vga_colour = 3'b001;
      rand_rd();
      cyc();
    end
    vga_plot = 0; rst = 1; clear_start = 0;
    cyc();
    chk("busy after rst", 32'(busy), 0);
    rst = 0;
    read_at(10, 5, 3'b011, "partial clear kept");
    read_at(159, 119, 3'b001, "plot ahead of clear");

    busy_cycles = 0;
    clear_colour = 3'b101; clear_start = 1;
    n = 0;
    while (clear_done !== 1'b1 && n < 20000) begin
      rand_rd();
      cyc();
      n++;
    end
    chk("clear finished", 32'(clear_done), 1);
    chk("clear length", 32'(busy_cycles), 19200);
    read_at(0, 0, 3'b101, "clear 0,0");
    read_at(159, 119, 3'b101, "clear overwrote plot");
    read_at(37, 88, 3'b101, "clear 37,88");
    chk("done held", 32'(clear_done), 1);
    clear_start = 0;
    cyc();
    chk("done falls", 32'(clear_done), 0);

    n = 0;
    for (int i = 0; n < 65540; i++) begin
      vga_plot = 1;
      vga_colour = 3'($urandom);
      if (i % 64 == 0) begin
        vga_x = 8'($urandom_range(160, 255));
        vga_y = 7'($urandom_range(0, 127));
      end else begin
        vga_x = 8'($urandom_range(0, 159));
        vga_y = 7'($urandom_range(0, 119));
        n++;
      end
      rand_rd();
      cyc();
    end
    vga_plot = 0;
    cyc();
    chk("plot count saturates", 32'(plot_count), 65535);
    chk("drop count saturates", 32'(drop_count), 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
